nabp_shifter: RTL and testbench

NABP_SHIFTER -- requirements
Module: nabp_shifter

---
 rtl/nabp_pkg.sv | 35 +++
 rtl/nabp_shifter_if.sv | 59 +++++
 rtl/nabp_shift_reg.sv | 43 ++++
 rtl/nabp_shifter.sv | 125 ++++++++++++
 tb/tb_nabp_shifter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nabp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nabp_pkg
// Description : Shared definitions for the NABP projection-line shifter:
//               controller state encoding, parameter defaults and the
//               shift-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nabp_pkg;

  // Default number of shift cycles per projection line.
  localparam int unsigned IMAGE_SIZE_DEF = 256;

  // Default width of line-buffer sample data.
  localparam int unsigned DATA_WIDTH_DEF = 12;

  // Counter must be able to hold the value IMAGE_SIZE itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Counter width for the default image size.
  localparam int unsigned CNT_W_DEF = $clog2(IMAGE_SIZE_DEF + 1);

  // Line controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } nabp_state_e;

endpackage : nabp_pkg
`default_nettype wire

// File: rtl/nabp_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : nabp_shifter_if
// Description : Bundle of the state-control, mapper and PE-array signals of
//               the projection-line shifter. The master modport is the
//               shifter side; the slave modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface nabp_shifter_if
  import nabp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  // State-control handshake
  logic                  ss_start;
  logic                  ss_busy;
  logic                  ss_done;
  // Mapper handshake
  logic                  sh_kick;
  logic                  sh_ack;
  logic                  sh_shift_enable;
  logic                  sh_done;
  // PE array / line buffer
  logic                  pe_ready;
  logic [DATA_WIDTH-1:0] rm_data;
  logic [DATA_WIDTH-1:0] pe_data;
  logic                  pe_valid;

  modport master (
    input  ss_start,
    output ss_busy,
    output ss_done,
    output sh_kick,
    input  sh_ack,
    output sh_shift_enable,
    output sh_done,
    input  pe_ready,
    input  rm_data,
    output pe_data,
    output pe_valid
  );

  modport slave (
    output ss_start,
    input  ss_busy,
    input  ss_done,
    input  sh_kick,
    output sh_ack,
    input  sh_shift_enable,
    input  sh_done,
    output pe_ready,
    output rm_data,
    input  pe_data,
    input  pe_valid
  );

endinterface : nabp_shifter_if
`default_nettype wire

// File: rtl/nabp_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : nabp_shift_reg
// Description : PE-array data path. Each shift-enable cycle captures the
//               line-buffer read data; the sample and its valid flag appear
//               on the outputs the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nabp_shift_reg
  import nabp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  shift_en_i,
  input  wire logic [DATA_WIDTH-1:0] rm_data_i,
  output logic      [DATA_WIDTH-1:0] pe_data_o,
  output logic                       pe_valid_o
);

  logic [DATA_WIDTH-1:0] pe_data_q;
  logic                  pe_valid_q;

  // Delay the enable by one cycle; capture a sample only on enabled cycles
  // so the last delivered value is held while the array is not fed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_data_q  <= '0;
      pe_valid_q <= 1'b0;
    end else begin
      pe_valid_q <= shift_en_i;
      if (shift_en_i) begin
        pe_data_q <= rm_data_i;
      end
    end
  end

  assign pe_data_o  = pe_data_q;
  assign pe_valid_o = pe_valid_q;

endmodule : nabp_shift_reg
`default_nettype wire

// File: rtl/nabp_shifter.sv
`default_nettype none
// ============================================================================
// Module      : nabp_shifter
// Description : Projection-line shifter. On a start request it kicks the
//               mapper, issues IMAGE_SIZE shift enables, waits one cycle for
//               the final line-buffer read, then reports completion.
//               Build option: define NABP_SHIFTER_STALL_EN to let pe_ready
//               throttle the shift enables; otherwise pe_ready is ignored
//               and the shift phase runs IMAGE_SIZE consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module nabp_shifter
  import nabp_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = IMAGE_SIZE_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  wire logic      clk,
  input  wire logic      reset,
  nabp_shifter_if.master bus
);

  localparam int unsigned          CNT_W    = cnt_width(IMAGE_SIZE);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  nabp_state_e      state_q;
  nabp_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             busy;
  logic             kick;
  logic             shift_en;
  logic             line_end;
  logic             line_done;
  logic             shift_allowed;

`ifdef NABP_SHIFTER_STALL_EN
  // Back-pressure from the PE array gates every shift step.
  assign shift_allowed = bus.pe_ready;
`else
  // pe_ready has no effect in this build; it is intentionally unused.
  logic unused_pe_ready;
  assign unused_pe_ready = bus.pe_ready;
  assign shift_allowed   = 1'b1;
`endif

  // State and shift-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and one-hot control outputs; only one of kick / shift /
  // line_end / line_done can be high since each belongs to a single state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = (state_q != ST_IDLE);
    kick      = 1'b0;
    shift_en  = 1'b0;
    line_end  = 1'b0;
    line_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ss_start) begin
          state_d = ST_KICK;
          cnt_d   = '0;
        end
      end
      ST_KICK: begin
        kick = 1'b1;
        if (bus.sh_ack) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = shift_allowed;
        if (shift_allowed) begin
          cnt_d = cnt_q + CNT_ONE;
          // The enable issued this cycle is the last one of the line.
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        line_end = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        line_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ss_busy         = busy;
  assign bus.ss_done         = line_done;
  assign bus.sh_kick         = kick;
  assign bus.sh_shift_enable = shift_en;
  assign bus.sh_done         = line_end;

  nabp_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_reg (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (shift_en),
    .rm_data_i  (bus.rm_data),
    .pe_data_o  (bus.pe_data),
    .pe_valid_o (bus.pe_valid)
  );

endmodule : nabp_shifter
`default_nettype wire

// File: tb/tb_nabp_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nabp_shifter
// Description : Self-checking bench for nabp_shifter. Two instances
//               (IMAGE_SIZE 4 and 1) run the same directed scenarios against
//               a line-level reference model; literal expectations pin the
//               sample order, pulse counts and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nabp_shifter;
  import nabp_pkg::*;

  localparam int DW = 12;
  localparam int NI = 2;
`ifdef NABP_SHIFTER_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  function automatic int sz(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Stimulus
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic          ack [NI];
  logic [DW-1:0] rm  [NI];
  int            base = 0;

  // Observed DUT outputs
  logic          busy_o [NI];
  logic          kick_o [NI];
  logic          en_o   [NI];
  logic          shd_o  [NI];
  logic          ssd_o  [NI];
  logic          pv_o   [NI];
  logic [DW-1:0] data_o [NI];

  nabp_shifter_if #(.DATA_WIDTH(DW)) bus4 ();
  nabp_shifter_if #(.DATA_WIDTH(DW)) bus1 ();

  nabp_shifter #(.IMAGE_SIZE(4), .DATA_WIDTH(DW)) u_dut4 (
    .clk (clk), .reset (reset), .bus (bus4.master)
  );
  nabp_shifter #(.IMAGE_SIZE(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk (clk), .reset (reset), .bus (bus1.master)
  );

  assign bus4.ss_start = start;
  assign bus4.sh_ack   = ack[0];
  assign bus4.pe_ready = ready;
  assign bus4.rm_data  = rm[0];
  assign bus1.ss_start = start;
  assign bus1.sh_ack   = ack[1];
  assign bus1.pe_ready = ready;
  assign bus1.rm_data  = rm[1];

  assign busy_o[0] = bus4.ss_busy;         assign busy_o[1] = bus1.ss_busy;
  assign kick_o[0] = bus4.sh_kick;         assign kick_o[1] = bus1.sh_kick;
  assign en_o[0]   = bus4.sh_shift_enable; assign en_o[1]   = bus1.sh_shift_enable;
  assign shd_o[0]  = bus4.sh_done;         assign shd_o[1]  = bus1.sh_done;
  assign ssd_o[0]  = bus4.ss_done;         assign ssd_o[1]  = bus1.ss_done;
  assign pv_o[0]   = bus4.pe_valid;        assign pv_o[1]   = bus1.pe_valid;
  assign data_o[0] = bus4.pe_data;         assign data_o[1] = bus1.pe_data;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, inst, act, expv, $time);
    end
  endtask

  // Line-level reference: phase 0 idle, 1 kicking mapper, 2 shifting,
  // 3 waiting on final read, 4 reporting done.
  int            ph      [NI];
  int            nshift  [NI];
  int            kc      [NI];
  logic          exp_v   [NI];
  logic [DW-1:0] exp_d   [NI];
  int            line_pv [NI];

  // Activity logs for literal checks
  int            cyc_no = 0;
  int            en_n   [NI];
  int            pv_n   [NI];
  int            sd_n   [NI];
  int            ssd_n  [NI];
  int            first_en [NI];
  int            last_en  [NI];
  int            sd_cyc   [NI];
  int            ssd_cyc  [NI];
  logic [DW-1:0] got [16];
  int            ng = 0;

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin : p_cmp
    logic e_en;
    int   nact;
    cyc_no++;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        chk("rst_busy", i, busy_o[i], 0);
        chk("rst_kick", i, kick_o[i], 0);
        chk("rst_en",   i, en_o[i],   0);
        chk("rst_shd",  i, shd_o[i],  0);
        chk("rst_ssd",  i, ssd_o[i],  0);
        chk("rst_pv",   i, pv_o[i],   0);
        chk("rst_data", i, data_o[i], 0);
        ph[i] = 0; nshift[i] = 0; kc[i] = 0;
        exp_v[i] = 1'b0; exp_d[i] = '0; line_pv[i] = 0;
      end else begin
        e_en = (ph[i] == 2) && (!STALL || ready);
        chk("busy",     i, busy_o[i], (ph[i] != 0));
        chk("kick",     i, kick_o[i], (ph[i] == 1));
        chk("shift_en", i, en_o[i],   e_en);
        chk("sh_done",  i, shd_o[i],  (ph[i] == 3));
        chk("ss_done",  i, ssd_o[i],  (ph[i] == 4));
        chk("pe_valid", i, pv_o[i],   exp_v[i]);
        chk("pe_data",  i, data_o[i], exp_d[i]);
        nact = int'(kick_o[i]) + int'(en_o[i]) + int'(shd_o[i]) + int'(ssd_o[i]);
        chk("exclusive", i, (nact <= 1), 1);

        if (en_o[i] === 1'b1) begin
          en_n[i]++;
          if (first_en[i] < 0) first_en[i] = cyc_no;
          last_en[i] = cyc_no;
        end
        if (pv_o[i] === 1'b1) begin
          pv_n[i]++;
          line_pv[i]++;
          if (i == 0 && ng < 16) begin
            got[ng] = data_o[0];
            ng++;
          end
        end
        if (shd_o[i] === 1'b1) begin sd_n[i]++;  sd_cyc[i]  = cyc_no; end
        if (ssd_o[i] === 1'b1) begin ssd_n[i]++; ssd_cyc[i] = cyc_no; end
        if (ph[i] == 4) chk("pulses_per_line", i, line_pv[i], sz(i));

        // Advance the reference by one clock.
        exp_v[i] = e_en;
        if (e_en) exp_d[i] = rm[i];
        case (ph[i])
          0: if (start) begin ph[i] = 1; kc[i] = 0; line_pv[i] = 0; end
          1: if (ack[i]) begin ph[i] = 2; nshift[i] = 0; end else kc[i]++;
          2: if (e_en) begin
               nshift[i]++;
               if (nshift[i] == sz(i)) ph[i] = 3;
             end
          3: ph[i] = 4;
          default: ph[i] = 0;
        endcase
      end
    end
  end

  // One bench cycle: inputs change 2 time units after the rising edge.
  // The mapper acknowledges two cycles after its kick starts; line-buffer
  // data is base + number of samples already shifted.
  task automatic cyc(input logic s, input logic r);
    @(posedge clk);
    #2;
    start = s;
    ready = r;
    for (int i = 0; i < NI; i++) begin
      ack[i] = (ph[i] == 1) && (kc[i] >= 2);
      rm[i]  = DW'(base + nshift[i]);
    end
  endtask

  task automatic clr_logs();
    for (int i = 0; i < NI; i++) begin
      en_n[i] = 0; pv_n[i] = 0; sd_n[i] = 0; ssd_n[i] = 0;
      first_en[i] = -1; last_en[i] = -1; sd_cyc[i] = -1; ssd_cyc[i] = -1;
    end
    ng = 0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      ack[i] = 1'b0;
      rm[i]  = '0;
    end
    clr_logs();

    // Reset state
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);

    // Line with continuous readiness; start on the first edge after release.
    base = 10;
    clr_logs();
    @(posedge clk);
    #2;
    reset = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) chk("sampleA", 0, got[k], 10 + k);
    chk("enA",     0, en_n[0], 4);
    chk("spanA",   0, last_en[0] - first_en[0] + 1, 4);
    chk("shdA",    0, sd_n[0], 1);
    chk("ssdA",    0, ssd_n[0], 1);
    chk("enA",     1, en_n[1], 1);
    chk("pvA",     1, pv_n[1], 1);
    chk("shd_latA", 1, sd_cyc[1] - last_en[1], 1);
    chk("ssd_latA", 1, ssd_cyc[1] - sd_cyc[1], 1);

    // Alternating readiness
    base = 20;
    clr_logs();
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b0, (k % 2) == 0);
    chk("enB",  0, en_n[0], 4);
    chk("pvB",  0, pv_n[0], 4);
    chk("ngB",  0, ng, 4);
    for (int k = 0; k < 4; k++) chk("sampleB", 0, got[k], 20 + k);
    chk("ssdB", 0, ssd_n[0], 1);

    // Second start while the line is in progress is dropped.
    base = 30;
    clr_logs();
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1);
    chk("ssdC", 0, ssd_n[0], 1);
    chk("ssdC", 1, ssd_n[1], 1);
    chk("enC",  0, en_n[0], 4);

    // Reset on the second shift cycle clears everything at once.
    base = 40;
    clr_logs();
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_busy", 0, busy_o[0], 0);
    chk("async_en",   0, en_o[0],   0);
    chk("async_pv",   0, pv_o[0],   0);
    chk("async_data", 0, data_o[0], 0);
    cyc(1'b0, 1'b1);
    reset = 1'b0;
    base = 50;
    clr_logs();
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) chk("sampleD", 0, got[k], 50 + k);
    chk("ssdD", 0, ssd_n[0], 1);
    chk("ssdD", 1, ssd_n[1], 1);

    // pe_ready held low: shifts proceed only when back-pressure is absent.
    base = 60;
    clr_logs();
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0);
    chk("enF_low", 0, en_n[0], STALL ? 0 : 4);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1);
    chk("enF",   0, en_n[0], 4);
    chk("spanF", 0, last_en[0] - first_en[0] + 1, 4);
    chk("ssdF",  0, ssd_n[0], 1);
    for (int k = 0; k < 4; k++) chk("sampleF", 0, got[k], 60 + k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nabp_shifter
`default_nettype wire
